// File: rtl/xocc_pkg.sv
// Shared definitions for the XOCC multi-queue interface.
//   - function / sub-function one-hot bit positions
//   - rs2 bit ranges for queue_id and field_id
//   - result encodings and a small flag-packing helper
package xocc_pkg;

   // func one-hot positions
   localparam int FUNC_NORMAL  = 0;
   localparam int FUNC_DELAYED = 1;

   // sub_func positions for normal (non-committing) ops
   localparam int SUB_PUSH_RDY  = 0;
   localparam int SUB_POP_RDY   = 1;
   localparam int SUB_READ_RSP  = 2;
   localparam int SUB_OCCUPANCY = 3;

   // sub_func positions for delayed (committing) ops
   localparam int SUB_PUSH_CMD  = 0;
   localparam int SUB_WRITE_CMD = 1;
   localparam int SUB_POP_RSP   = 2;

   // rs2 field ranges
   localparam int QID_LSB = 0;
   localparam int QID_MSB = 3;
   localparam int FID_LSB = 4;
   localparam int FID_MSB = 11;

   // result encodings
   localparam logic [31:0] RES_ZERO = 32'h0000_0000;
   localparam logic [31:0] RES_ONE  = 32'h0000_0001;

   localparam int OCC_CMD_LSB = 0;
   localparam int OCC_RSP_LSB = 16;

   function automatic logic [31:0] flag32(input logic b);
      return {31'b0, b};
   endfunction

endpackage

// File: rtl/xocc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A write to a full FIFO is dropped even when a read happens in the same
// cycle; a read of an empty FIFO is ignored. rd_data is forced to 0 while
// empty so no stale entry is ever presented downstream.
// Ports:
//   xocc_clk, cpurst_b   clock, async active-low reset
//   wr_en, wr_data       push side
//   rd_en, rd_data       pop side (rd_data is the current head)
//   full, empty, count   status
module xocc_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                       xocc_clk,
   input  logic                       cpurst_b,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge xocc_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge xocc_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/xocc_multiq_if.sv
// XOCC multi-queue interface: per-queue command staging registers and
// command/response FIFO pairs between the core EX1 stage and a DSA.
// Optional feature macro: XOCC_OCC_CNT_EN enables the occupancy op
// (returns {rsp_count in [23:16], cmd_count in [7:0]}); otherwise it
// returns 0.
// Ports:
//   xocc_clk, cpurst_b               clock, async active-low reset
//   idu_iu_ex1_inst_vld              EX1 instruction valid
//   idu_iu_ex1_xocc_sel              XOCC unit selected
//   idu_xocc_ex1_func / _sub_func    one-hot op select
//   idu_xocc_ex1_rs1                 write data
//   idu_xocc_ex1_rs2                 [3:0] queue_id, [11:4] field_id
//   iu_rtu_ex1_xocc_cmplt / _data    zero-latency completion and result
//   dsa_cmd_*                        command FIFO heads toward the DSA
//   dsa_rsp_*                        response FIFO push side from the DSA
module xocc_multiq_if
   import xocc_pkg::*;
#(
   parameter int NUM_Q     = 4,
   parameter int CMD_WORDS = 3,
   parameter int DEPTH     = 16
) (
   input  logic                          xocc_clk,
   input  logic                          cpurst_b,
   input  logic                          idu_iu_ex1_inst_vld,
   input  logic                          idu_iu_ex1_xocc_sel,
   input  logic [4:0]                    idu_xocc_ex1_func,
   input  logic [4:0]                    idu_xocc_ex1_sub_func,
   input  logic [31:0]                   idu_xocc_ex1_rs1,
   input  logic [31:0]                   idu_xocc_ex1_rs2,
   output logic                          iu_rtu_ex1_xocc_cmplt,
   output logic [31:0]                   iu_rtu_ex1_xocc_data,
   output logic [NUM_Q*CMD_WORDS*32-1:0] dsa_cmd_data,
   output logic [NUM_Q-1:0]              dsa_cmd_empty,
   input  logic [NUM_Q-1:0]              dsa_cmd_rd_en,
   input  logic [NUM_Q*32-1:0]           dsa_rsp_data,
   input  logic [NUM_Q-1:0]              dsa_rsp_wr_en,
   output logic [NUM_Q-1:0]              dsa_rsp_full
);

   localparam int CMD_BITS = CMD_WORDS * 32;
   localparam int CNT_W    = $clog2(DEPTH) + 1;

   logic [4:0] sel;
   logic [3:0] qid;
   logic [7:0] fid;
   logic       q_ok;
   logic       f_ok;
   logic       normal;
   logic       delayed;

   logic op_push_rdy, op_pop_rdy, op_read_rsp;
   logic op_push_cmd, op_write_cmd, op_pop_rsp;

   logic [NUM_Q-1:0][CMD_BITS-1:0] stage;
   logic [NUM_Q-1:0]               cmd_wr;
   logic [NUM_Q-1:0]               cmd_full;
   logic [NUM_Q-1:0]               rsp_rd;
   logic [NUM_Q-1:0]               rsp_empty;
   logic [NUM_Q-1:0][31:0]         rsp_head;
   logic [NUM_Q-1:0][CNT_W-1:0]    cmd_cnt;
   logic [NUM_Q-1:0][CNT_W-1:0]    rsp_cnt;

   logic        cmd_full_q;
   logic        rsp_empty_q;
   logic [31:0] rsp_head_q;
   logic [31:0] result;

   assign sel     = idu_xocc_ex1_func & {5{idu_iu_ex1_xocc_sel}};
   assign qid     = idu_xocc_ex1_rs2[QID_MSB:QID_LSB];
   assign fid     = idu_xocc_ex1_rs2[FID_MSB:FID_LSB];
   assign q_ok    = int'(qid) < NUM_Q;
   assign f_ok    = int'(fid) < CMD_WORDS;

   // Normal ops only read state, so they are not qualified by inst_vld.
   assign normal  = sel[FUNC_NORMAL];
   assign delayed = sel[FUNC_DELAYED] & idu_iu_ex1_inst_vld;

   assign op_push_rdy  = normal  & idu_xocc_ex1_sub_func[SUB_PUSH_RDY];
   assign op_pop_rdy   = normal  & idu_xocc_ex1_sub_func[SUB_POP_RDY];
   assign op_read_rsp  = normal  & idu_xocc_ex1_sub_func[SUB_READ_RSP];
   assign op_push_cmd  = delayed & idu_xocc_ex1_sub_func[SUB_PUSH_CMD];
   assign op_write_cmd = delayed & idu_xocc_ex1_sub_func[SUB_WRITE_CMD];
   assign op_pop_rsp   = delayed & idu_xocc_ex1_sub_func[SUB_POP_RSP];

   // Staging is kept after a push so a command can be re-sent with only
   // the changed fields rewritten.
   always_ff @(posedge xocc_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         stage <= '0;
      end else if (op_write_cmd && f_ok) begin
         for (int i = 0; i < NUM_Q; i++) begin
            for (int j = 0; j < CMD_WORDS; j++) begin
               if (qid == 4'(i) && fid == 8'(j)) begin
                  stage[i][j*32 +: 32] <= idu_xocc_ex1_rs1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_Q; g++) begin : g_q
      // An out-of-range qid matches no queue, so it cannot change state.
      assign cmd_wr[g] = op_push_cmd & (qid == 4'(g));
      assign rsp_rd[g] = op_pop_rsp  & (qid == 4'(g));

      xocc_sync_fifo #(.WIDTH(CMD_BITS), .DEPTH(DEPTH)) u_cmd_fifo (
         .xocc_clk (xocc_clk),
         .cpurst_b (cpurst_b),
         .wr_en    (cmd_wr[g]),
         .wr_data  (stage[g]),
         .rd_en    (dsa_cmd_rd_en[g]),
         .rd_data  (dsa_cmd_data[g*CMD_BITS +: CMD_BITS]),
         .full     (cmd_full[g]),
         .empty    (dsa_cmd_empty[g]),
         .count    (cmd_cnt[g])
      );

      xocc_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rsp_fifo (
         .xocc_clk (xocc_clk),
         .cpurst_b (cpurst_b),
         .wr_en    (dsa_rsp_wr_en[g]),
         .wr_data  (dsa_rsp_data[g*32 +: 32]),
         .rd_en    (rsp_rd[g]),
         .rd_data  (rsp_head[g]),
         .full     (dsa_rsp_full[g]),
         .empty    (rsp_empty[g]),
         .count    (rsp_cnt[g])
      );
   end

`ifdef XOCC_OCC_CNT_EN
   logic             op_occupancy;
   logic [CNT_W-1:0] cmd_cnt_q;
   logic [CNT_W-1:0] rsp_cnt_q;

   assign op_occupancy = normal & idu_xocc_ex1_sub_func[SUB_OCCUPANCY];

   always_comb begin
      cmd_cnt_q = '0;
      rsp_cnt_q = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (qid == 4'(i)) begin
            cmd_cnt_q = cmd_cnt[i];
            rsp_cnt_q = rsp_cnt[i];
         end
      end
   end
`endif

   always_comb begin
      cmd_full_q  = 1'b0;
      rsp_empty_q = 1'b1;
      rsp_head_q  = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (qid == 4'(i)) begin
            cmd_full_q  = cmd_full[i];
            rsp_empty_q = rsp_empty[i];
            rsp_head_q  = rsp_head[i];
         end
      end
   end

   // Result is the OR of every selected op's contribution.
   always_comb begin
      result = RES_ZERO;
      if (op_push_rdy && q_ok) result = result | flag32(~cmd_full_q);
      if (op_pop_rdy  && q_ok) result = result | flag32(~rsp_empty_q);
      if (op_read_rsp && q_ok) result = result | rsp_head_q;
      if (op_push_cmd && q_ok) result = result | flag32(~cmd_full_q);
      if (op_pop_rsp  && q_ok) result = result | flag32(~rsp_empty_q);
      if (op_write_cmd)        result = result | RES_ONE;
`ifdef XOCC_OCC_CNT_EN
      if (op_occupancy && q_ok) begin
         result = result | (32'(8'(rsp_cnt_q)) << OCC_RSP_LSB)
                         | (32'(8'(cmd_cnt_q)) << OCC_CMD_LSB);
      end
`endif
   end

   assign iu_rtu_ex1_xocc_cmplt = idu_iu_ex1_inst_vld & (|sel);
   assign iu_rtu_ex1_xocc_data  = result;

`ifdef XOCC_OCC_CNT_EN
   logic unused_bits;
   assign unused_bits = ^{idu_xocc_ex1_rs2[31:12], idu_xocc_ex1_func[4:2],
                          idu_xocc_ex1_sub_func[4]};
`else
   logic unused_bits;
   assign unused_bits = ^{idu_xocc_ex1_rs2[31:12], idu_xocc_ex1_func[4:2],
                          idu_xocc_ex1_sub_func[4:3], cmd_cnt, rsp_cnt};
`endif

endmodule
